// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with PC, ROM drive and IF/ID output stage
module inst_fetch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              ROM_AW   = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [31:0]       id_inst,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            id_valid_q, id_valid_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;

    logic            load;
    logic            redir_bad;
    logic            inc_oob;
    logic [PC_W-1:0] pc_inc;

    assign load      = !id_valid_q || id_ready;
    assign pc_inc    = pc_q + PC_W'(4);
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc[PC_W-1:ROM_AW+2] != '0);
    assign inc_oob   = (pc_inc[PC_W-1:ROM_AW+2] != '0);

    assign rom_ce    = (state_q == RUN);
    assign rom_addr  = rom_ce ? pc_q[ROM_AW+1:2] : '0;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign fetch_err = (state_q == ERR);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;

        // A redirect outranks everything outside ERR; the in-flight ROM word is discarded.
        if (state_q != ERR && redirect_valid) begin
            id_valid_d = 1'b0;
            if (redir_bad) begin
                state_d = ERR;
            end else begin
                pc_d    = redirect_pc;
                state_d = halt ? HALTED : RUN;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = halt ? HALTED : RUN;
                end
                RUN: begin
                    if (halt) begin
                        state_d = HALTED;
                        if (id_ready) id_valid_d = 1'b0;
                    end else if (load) begin
                        id_pc_d    = pc_q;
                        id_inst_d  = rom_inst;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc;
                        // Last ROM word is still delivered before faulting.
                        if (inc_oob) state_d = ERR;
                    end
                end
                HALTED: begin
                    if (id_ready) id_valid_d = 1'b0;
                    if (!halt) state_d = RUN;
                end
                default: begin
                    if (id_ready) id_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [5:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        fetch_err;

    logic [31:0] rom [64];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_addr];

    inst_fetch_ctrl #(.PC_W(32), .ROM_AW(6), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .fetch_err      (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rom[0] = 32'h34011100;
        rom[1] = 32'h34020020;
        rom[2] = 32'h3403ff00;
        rom[3] = 32'h3404ffff;
        for (int i = 4; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; id_ready = 1'b1;
        #12;
        check("rst_ce", rom_ce, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_valid", id_valid, 0);
        check("rst_pc", id_pc, 0);
        check("rst_inst", id_inst, 0);
        check("rst_err", fetch_err, 0);

        release_rst();
        check("boot_ce", rom_ce, 0);
        step();
        check("c1_ce", rom_ce, 1);
        check("c1_addr", rom_addr, 0);
        check("c1_valid", id_valid, 0);
        step();
        check("c2_valid", id_valid, 1);
        check("c2_pc", id_pc, 32'h0);
        check("c2_inst", id_inst, 32'h34011100);
        step();
        check("c3_pc", id_pc, 32'h4);
        check("c3_inst", id_inst, 32'h34020020);
        step();
        check("c4_pc", id_pc, 32'h8);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", id_pc, 32'h8);
            check("stall_inst", id_inst, 32'h3403ff00);
            check("stall_addr", rom_addr, 3);
            check("stall_ce", rom_ce, 1);
        end
        id_ready = 1'b1;
        step();
        check("unstall_pc", id_pc, 32'hC);
        check("unstall_inst", id_inst, 32'h3404ffff);
        check("unstall_addr", rom_addr, 4);

        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        check("redir_flush", id_valid, 0);
        check("redir_addr", rom_addr, 6'h10);
        redirect_valid = 1'b0; id_ready = 1'b1;
        step();
        check("redir_pc", id_pc, 32'h40);
        check("redir_inst", id_inst, 32'hC0DE0010);

        halt = 1'b1;
        step();
        check("halt_ce", rom_ce, 0);
        check("halt_drain", id_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_ce_hold", rom_ce, 0);
            check("halt_valid_hold", id_valid, 0);
        end
        halt = 1'b0;
        step();
        check("resume_ce", rom_ce, 1);
        check("resume_addr", rom_addr, 6'h11);
        step();
        check("resume_pc", id_pc, 32'h44);
        check("resume_inst", id_inst, 32'hC0DE0011);

        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        check("hr_ce", rom_ce, 0);
        check("hr_valid", id_valid, 0);
        halt = 1'b0; redirect_valid = 1'b0;
        step();
        check("hr_resume_addr", rom_addr, 6'h08);
        step();
        check("hr_pc", id_pc, 32'h20);
        check("hr_inst", id_inst, 32'hC0DE0008);

        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("mis_err", fetch_err, 1);
        check("mis_ce", rom_ce, 0);
        check("mis_valid", id_valid, 0);
        step();
        step();
        check("mis_sticky", fetch_err, 1);
        check("mis_valid_hold", id_valid, 0);

        rst = 1'b1;
        #1;
        check("rst2_err", fetch_err, 0);
        release_rst();
        check("rst2_boot_ce", rom_ce, 0);
        step();
        check("rst2_ce", rom_ce, 1);
        check("rst2_addr", rom_addr, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("oor_err", fetch_err, 1);
        check("oor_ce", rom_ce, 0);
        step();
        check("oor_sticky", fetch_err, 1);
        check("oor_valid", id_valid, 0);

        rst = 1'b1;
        release_rst();
        redirect_valid = 1'b1; redirect_pc = 32'hF8;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr0", rom_addr, 6'h3E);
        check("wrap_valid0", id_valid, 0);
        step();
        check("wrap_pc0", id_pc, 32'hF8);
        check("wrap_addr1", rom_addr, 6'h3F);
        step();
        check("wrap_pc1", id_pc, 32'hFC);
        check("wrap_inst1", id_inst, 32'hC0DE003F);
        check("wrap_valid1", id_valid, 1);
        check("wrap_err", fetch_err, 1);
        check("wrap_ce", rom_ce, 0);
        id_ready = 1'b0;
        step();
        check("err_hold_valid", id_valid, 1);
        check("err_hold_pc", id_pc, 32'hFC);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", id_valid, 0);
        check("async_pc", id_pc, 0);
        check("async_inst", id_inst, 0);
        check("async_err", fetch_err, 0);
        check("async_ce", rom_ce, 0);
        check("async_addr", rom_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
